// File: rtl/wb_load_unit_if.sv
// Request, RAM-response and regfile-writeback signals for wb_load_unit.
// The slave modport is the unit's view; master is the MEM stage/RAM/regfile side.
interface wb_load_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_pc;
    logic              in_wen;
    logic [REG_AW-1:0] in_waddr;
    logic [31:0]       in_wdata;
    logic [3:0]        in_op;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_rt_old;
    logic              in_cp0_sel;
    logic [31:0]       in_cp0_data;
    logic              ram_rvalid;
    logic [31:0]       ram_rdata;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_pc;
    logic              wb_wen;
    logic [REG_AW-1:0] wb_waddr;
    logic [31:0]       wb_wdata;
    logic              load_done;
    logic              misalign_err;
    logic              bus_err;
    logic              busy;

    modport slave (
        input  in_valid, in_pc, in_wen, in_waddr, in_wdata, in_op, in_addr,
               in_rt_old, in_cp0_sel, in_cp0_data, ram_rvalid, ram_rdata,
        output in_ready, wb_valid, wb_pc, wb_wen, wb_waddr, wb_wdata,
               load_done, misalign_err, bus_err, busy
    );

    modport master (
        output in_valid, in_pc, in_wen, in_waddr, in_wdata, in_op, in_addr,
               in_rt_old, in_cp0_sel, in_cp0_data, ram_rvalid, ram_rdata,
        input  in_ready, wb_valid, wb_pc, wb_wen, wb_waddr, wb_wdata,
               load_done, misalign_err, bus_err, busy
    );
endinterface

// File: rtl/wb_load_unit.sv
// Sequential writeback stage: accepts one MEM request, waits for RAM read data
// on loads, formats the result and drives a registered one-cycle regfile write.
module wb_load_unit #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    wb_load_unit_if.slave bus
);
    typedef enum logic {ST_IDLE, ST_WAIT} state_e;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3,
        OP_LHU  = 4'd4, OP_LW = 4'd5, OP_LWL = 4'd6, OP_LWR = 4'd7
    } op_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              req_wen_q, req_wen_d;
    logic [REG_AW-1:0] req_waddr_q, req_waddr_d;
    logic [3:0]        req_op_q, req_op_d;
    logic [1:0]        req_off_q, req_off_d;
    logic [31:0]       req_rt_q, req_rt_d;

    logic              wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0] wb_pc_q, wb_pc_d;
    logic              wb_wen_q, wb_wen_d;
    logic [REG_AW-1:0] wb_waddr_q, wb_waddr_d;
    logic [31:0]       wb_wdata_q, wb_wdata_d;
    logic              load_done_q, load_done_d;
    logic              misalign_q, misalign_d;
    logic              bus_err_q, bus_err_d;

    logic              in_is_load;
    logic              in_misaligned;

    function automatic logic [31:0] fmt_load(input logic [3:0] op, input logic [1:0] o,
                                             input logic [31:0] m, input logic [31:0] r);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (o)
            2'd0:    b = m[7:0];
            2'd1:    b = m[15:8];
            2'd2:    b = m[23:16];
            default: b = m[31:24];
        endcase
        h = o[1] ? m[31:16] : m[15:0];
        case (op)
            OP_LB:   res = {{24{b[7]}}, b};
            OP_LBU:  res = {24'd0, b};
            OP_LH:   res = {{16{h[15]}}, h};
            OP_LHU:  res = {16'd0, h};
            OP_LWL: begin
                case (o)
                    2'd0:    res = {m[7:0], r[23:0]};
                    2'd1:    res = {m[15:0], r[15:0]};
                    2'd2:    res = {m[23:0], r[7:0]};
                    default: res = m;
                endcase
            end
            OP_LWR: begin
                case (o)
                    2'd0:    res = m;
                    2'd1:    res = {r[31:24], m[31:8]};
                    2'd2:    res = {r[31:16], m[31:16]};
                    default: res = {r[31:8], m[31:24]};
                endcase
            end
            default: res = m;
        endcase
        return res;
    endfunction

    assign in_is_load    = (bus.in_op != OP_NONE) && (bus.in_op <= OP_LWR);
    assign in_misaligned = ((bus.in_op == OP_LH || bus.in_op == OP_LHU) && bus.in_addr[0])
                         || (bus.in_op == OP_LW && bus.in_addr[1:0] != 2'b00);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_pc_d    = req_pc_q;
        req_wen_d   = req_wen_q;
        req_waddr_d = req_waddr_q;
        req_op_d    = req_op_q;
        req_off_d   = req_off_q;
        req_rt_d    = req_rt_q;
        wb_valid_d  = 1'b0;
        wb_pc_d     = '0;
        wb_wen_d    = 1'b0;
        wb_waddr_d  = '0;
        wb_wdata_d  = '0;
        load_done_d = 1'b0;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (!in_is_load) begin
                        wb_valid_d = 1'b1;
                        wb_pc_d    = bus.in_pc;
                        wb_waddr_d = bus.in_waddr;
                        wb_wen_d   = bus.in_wen && (bus.in_waddr != '0);
                        wb_wdata_d = bus.in_cp0_sel ? bus.in_cp0_data : bus.in_wdata;
                    end else if (in_misaligned) begin
                        wb_valid_d = 1'b1;
                        wb_pc_d    = bus.in_pc;
                        wb_waddr_d = bus.in_waddr;
                        misalign_d = 1'b1;
                    end else begin
                        state_d     = ST_WAIT;
                        cnt_d       = '0;
                        req_pc_d    = bus.in_pc;
                        req_wen_d   = bus.in_wen;
                        req_waddr_d = bus.in_waddr;
                        req_op_d    = bus.in_op;
                        req_off_d   = bus.in_addr[1:0];
                        req_rt_d    = bus.in_rt_old;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.ram_rvalid) begin
                    state_d     = ST_IDLE;
                    wb_valid_d  = 1'b1;
                    wb_pc_d     = req_pc_q;
                    wb_waddr_d  = req_waddr_q;
                    wb_wen_d    = req_wen_q && (req_waddr_q != '0);
                    wb_wdata_d  = fmt_load(req_op_q, req_off_q, bus.ram_rdata, req_rt_q);
                    load_done_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    // The increment that would reach MAX_WAIT ends the wait instead.
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    wb_valid_d = 1'b1;
                    wb_pc_d    = req_pc_q;
                    wb_waddr_d = req_waddr_q;
                    bus_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_pc_q    <= '0;
            req_wen_q   <= 1'b0;
            req_waddr_q <= '0;
            req_op_q    <= '0;
            req_off_q   <= '0;
            req_rt_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_pc_q     <= '0;
            wb_wen_q    <= 1'b0;
            wb_waddr_q  <= '0;
            wb_wdata_q  <= '0;
            load_done_q <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_pc_q    <= req_pc_d;
            req_wen_q   <= req_wen_d;
            req_waddr_q <= req_waddr_d;
            req_op_q    <= req_op_d;
            req_off_q   <= req_off_d;
            req_rt_q    <= req_rt_d;
            wb_valid_q  <= wb_valid_d;
            wb_pc_q     <= wb_pc_d;
            wb_wen_q    <= wb_wen_d;
            wb_waddr_q  <= wb_waddr_d;
            wb_wdata_q  <= wb_wdata_d;
            load_done_q <= load_done_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus.in_ready     = (state_q == ST_IDLE);
    assign bus.busy         = (state_q == ST_WAIT);
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_pc        = wb_pc_q;
    assign bus.wb_wen       = wb_wen_q;
    assign bus.wb_waddr     = wb_waddr_q;
    assign bus.wb_wdata     = wb_wdata_q;
    assign bus.load_done    = load_done_q;
    assign bus.misalign_err = misalign_q;
    assign bus.bus_err      = bus_err_q;
endmodule

// File: tb/tb_wb_load_unit.sv
// Directed bench for wb_load_unit: stimulus pushes hand-computed writebacks into
// a queue, a negedge monitor pops and compares every wb_valid cycle.
module tb_wb_load_unit;
    typedef struct packed {
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ld;
        logic        mis;
        logic        berr;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    exp_t act_e;
    exp_t req_e;

    wb_load_unit_if #(.ADDR_W(32), .REG_AW(5)) bus_if ();

    wb_load_unit #(.ADDR_W(32), .REG_AW(5), .MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (rst) begin
            act_e = '{bus_if.wb_pc, bus_if.wb_wen, bus_if.wb_waddr, bus_if.wb_wdata,
                      bus_if.load_done, bus_if.misalign_err, bus_if.bus_err};
            checks++;
            if (bus_if.wb_valid) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wb: got %h, required no writeback", act_e);
                end else begin
                    req_e = exp_q.pop_front();
                    if (act_e !== req_e)
                        begin
                            errors++;
                            $display("FAIL wb_out: got pc=%h wen=%b waddr=%0d wdata=%h ld=%b mis=%b berr=%b, required pc=%h wen=%b waddr=%0d wdata=%h ld=%b mis=%b berr=%b",
                                act_e.pc, act_e.wen, act_e.waddr, act_e.wdata, act_e.ld, act_e.mis, act_e.berr,
                                req_e.pc, req_e.wen, req_e.waddr, req_e.wdata, req_e.ld, req_e.mis, req_e.berr);
                        end
                end
            end else if (act_e !== '0) begin
                errors++;
                $display("FAIL idle_outputs: got %h, required all zero", act_e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_wb(input logic [31:0] pc, input logic wen, input logic [4:0] waddr,
                             input logic [31:0] wdata, input logic ld, input logic mis,
                             input logic berr);
        exp_t e;
        e = '{pc, wen, waddr, wdata, ld, mis, berr};
        exp_q.push_back(e);
    endtask

    // Presents one request for a single clock; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] pc, input logic wen,
                         input logic [4:0] waddr, input logic [31:0] wdata,
                         input logic [31:0] addr, input logic [31:0] rt,
                         input logic cp0_sel, input logic [31:0] cp0_data);
        chk("in_ready_before_issue", 32'(bus_if.in_ready), 32'd1);
        bus_if.in_valid    = 1'b1;
        bus_if.in_op       = op;
        bus_if.in_pc       = pc;
        bus_if.in_wen      = wen;
        bus_if.in_waddr    = waddr;
        bus_if.in_wdata    = wdata;
        bus_if.in_addr     = addr;
        bus_if.in_rt_old   = rt;
        bus_if.in_cp0_sel  = cp0_sel;
        bus_if.in_cp0_data = cp0_data;
        @(posedge clk); #1;
        bus_if.in_valid    = 1'b0;
    endtask

    // Issues a load and answers it lat cycles after acceptance, checking the stall.
    task automatic do_load(input logic [3:0] op, input logic [31:0] pc, input logic wen,
                           input logic [4:0] waddr, input logic [31:0] addr,
                           input logic [31:0] rt, input logic [31:0] m, input int lat);
        issue(op, pc, wen, waddr, 32'h0, addr, rt, 1'b0, 32'h0);
        for (int i = 0; i < lat; i++) begin
            chk("busy_in_wait", 32'(bus_if.busy), 32'd1);
            chk("in_ready_in_wait", 32'(bus_if.in_ready), 32'd0);
            if (i == lat - 1) begin
                bus_if.ram_rvalid = 1'b1;
                bus_if.ram_rdata  = m;
            end
            @(posedge clk); #1;
        end
        bus_if.ram_rvalid = 1'b0;
        chk("busy_after_load", 32'(bus_if.busy), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus_if.in_valid = 1'b0;   bus_if.in_op = 4'd0;      bus_if.in_pc = '0;
        bus_if.in_wen = 1'b0;     bus_if.in_waddr = '0;     bus_if.in_wdata = '0;
        bus_if.in_addr = '0;      bus_if.in_rt_old = '0;    bus_if.in_cp0_sel = 1'b0;
        bus_if.in_cp0_data = '0;  bus_if.ram_rvalid = 1'b0; bus_if.ram_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wb_valid", 32'(bus_if.wb_valid), 32'd0);
        chk("reset_in_ready", 32'(bus_if.in_ready), 32'd1);
        chk("reset_busy", 32'(bus_if.busy), 32'd0);
        rst = 1'b1;

        // Back-to-back ALU ops; op 9 behaves as op 0.
        expect_wb(32'h100, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 1'b0);
        issue(4'd0, 32'h100, 1'b1, 5'd5, 32'h1234, 32'h0, 32'h0, 1'b0, 32'h0);
        expect_wb(32'h104, 1'b1, 5'd6, 32'hBEEF, 1'b0, 1'b0, 1'b0);
        issue(4'd9, 32'h104, 1'b1, 5'd6, 32'hBEEF, 32'h0, 32'h0, 1'b0, 32'h0);

        // LB / LBU of byte 3 of 0x80FFFF7F, answered after 3 cycles.
        expect_wb(32'h200, 1'b1, 5'd7, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0);
        do_load(4'd1, 32'h200, 1'b1, 5'd7, 32'h203, 32'h0, 32'h80FF_FF7F, 3);
        expect_wb(32'h204, 1'b1, 5'd8, 32'h0000_0080, 1'b1, 1'b0, 1'b0);
        do_load(4'd2, 32'h204, 1'b1, 5'd8, 32'h203, 32'h0, 32'h80FF_FF7F, 3);

        // Unaligned merges.
        expect_wb(32'h300, 1'b1, 5'd9, 32'hCCDD_3344, 1'b1, 1'b0, 1'b0);
        do_load(4'd6, 32'h300, 1'b1, 5'd9, 32'h301, 32'h1122_3344, 32'hAABB_CCDD, 1);
        expect_wb(32'h304, 1'b1, 5'd9, 32'h1122_AABB, 1'b1, 1'b0, 1'b0);
        do_load(4'd7, 32'h304, 1'b1, 5'd9, 32'h302, 32'h1122_3344, 32'hAABB_CCDD, 2);

        // Misaligned LW and LHU never enter WAIT.
        expect_wb(32'h400, 1'b0, 5'd10, 32'h0, 1'b0, 1'b1, 1'b0);
        issue(4'd5, 32'h400, 1'b1, 5'd10, 32'h0, 32'h402, 32'h0, 1'b0, 32'h0);
        chk("misalign_lw_not_busy", 32'(bus_if.busy), 32'd0);
        expect_wb(32'h404, 1'b0, 5'd11, 32'h0, 1'b0, 1'b1, 1'b0);
        issue(4'd4, 32'h404, 1'b1, 5'd11, 32'h0, 32'h401, 32'h0, 1'b0, 32'h0);
        chk("misalign_lhu_not_busy", 32'(bus_if.busy), 32'd0);

        // LH of the upper half.
        expect_wb(32'h408, 1'b1, 5'd12, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0);
        do_load(4'd3, 32'h408, 1'b1, 5'd12, 32'h402, 32'h0, 32'h8001_0000, 2);

        // Timeout after 4 WAIT cycles; a late rvalid is dropped.
        expect_wb(32'h500, 1'b0, 5'd13, 32'h0, 1'b0, 1'b0, 1'b1);
        issue(4'd5, 32'h500, 1'b1, 5'd13, 32'h0, 32'h500, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("busy_before_timeout", 32'(bus_if.busy), 32'd1);
            @(posedge clk); #1;
        end
        chk("idle_after_timeout", 32'(bus_if.busy), 32'd0);
        bus_if.ram_rvalid = 1'b1;
        bus_if.ram_rdata  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus_if.ram_rvalid = 1'b0;
        @(posedge clk); #1;

        // MFC0 with zero data; cp0_sel on a load is ignored.
        expect_wb(32'h600, 1'b1, 5'd14, 32'h0, 1'b0, 1'b0, 1'b0);
        issue(4'd0, 32'h600, 1'b1, 5'd14, 32'h55, 32'h0, 32'h0, 1'b1, 32'h0);
        expect_wb(32'h604, 1'b1, 5'd15, 32'h1357_9BDF, 1'b1, 1'b0, 1'b0);
        bus_if.in_cp0_sel  = 1'b1;
        bus_if.in_cp0_data = 32'hDEAD;
        issue(4'd5, 32'h604, 1'b1, 5'd15, 32'h0, 32'h604, 32'h0, 1'b1, 32'hDEAD);
        bus_if.in_cp0_sel = 1'b0;
        bus_if.ram_rvalid = 1'b1;
        bus_if.ram_rdata  = 32'h1357_9BDF;
        @(posedge clk); #1;
        bus_if.ram_rvalid = 1'b0;

        // Reset during WAIT discards the load.
        issue(4'd5, 32'h700, 1'b1, 5'd16, 32'h0, 32'h700, 32'h0, 1'b0, 32'h0);
        chk("busy_before_reset", 32'(bus_if.busy), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("idle_after_reset", 32'(bus_if.in_ready), 32'd1);
        chk("wb_valid_after_reset", 32'(bus_if.wb_valid), 32'd0);
        bus_if.ram_rvalid = 1'b1;
        bus_if.ram_rdata  = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus_if.ram_rvalid = 1'b0;
        @(posedge clk); #1;

        // Writes to r0 are suppressed for loads and ALU ops.
        expect_wb(32'h800, 1'b0, 5'd0, 32'h0000_0012, 1'b1, 1'b0, 1'b0);
        do_load(4'd2, 32'h800, 1'b1, 5'd0, 32'h800, 32'h0, 32'h0000_0012, 1);
        expect_wb(32'h804, 1'b0, 5'd0, 32'h77, 1'b0, 1'b0, 1'b0);
        issue(4'd0, 32'h804, 1'b1, 5'd0, 32'h77, 32'h0, 32'h0, 1'b0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_load_unit.md
Name: wb_load_unit

Overview:
Sequential successor to the combinational writeback stage. Accepts one MEM-stage writeback request per handshake and waits a variable number of cycles for RAM read data. It formats load results (byte/half/word plus unaligned LWL/LWR merge), applies an explicit CP0 override, and drives a registered one-cycle regfile write port. It also flags misaligned loads and RAM timeouts, and stalls MEM via in_ready while a load is outstanding.

Parameters:
ADDR_W, 32, width of pc/address buses
REG_AW, 5, register-file address width
MAX_WAIT, 16, cycles spent in WAIT without ram_rvalid before bus_err (>=1)
CNT_W, $clog2(MAX_WAIT+1), width of the wait counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-low
in_valid  in  1  MEM request valid
in_ready  out  1  unit can accept a request
in_pc  in  ADDR_W  instruction pc
in_wen  in  1  instruction writes a GPR
in_waddr  in  REG_AW  destination GPR
in_wdata  in  32  ALU/non-load result
in_op  in  4  0 none/ALU, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR; 8-15 treated as 0
in_addr  in  ADDR_W  load byte address
in_rt_old  in  32  current rt value, used for the LWL/LWR merge
in_cp0_sel  in  1  write in_cp0_data instead (MFC0)
in_cp0_data  in  32  CP0 read data
ram_rvalid  in  1  RAM read data valid
ram_rdata  in  32  RAM read word, little-endian lanes
wb_valid  out  1  regfile write slot this cycle
wb_pc  out  ADDR_W  pc of the retiring instruction
wb_wen  out  1  regfile write enable
wb_waddr  out  REG_AW  regfile write address
wb_wdata  out  32  regfile write data
load_done  out  1  one-cycle pulse when a load writes back
misalign_err  out  1  one-cycle pulse for an LH/LHU/LW address fault
bus_err  out  1  one-cycle pulse for a RAM timeout
busy  out  1  high while in WAIT

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE, counter 0, all wb_* outputs, load_done, misalign_err and bus_err set to 0. A pending load is discarded.
- in_ready = (state==IDLE). busy = (state==WAIT).
- Handshake: a request is accepted when in_valid && in_ready. All request fields are captured on acceptance.
- Non-load request (op 0 or 8-15), IDLE→IDLE:
  - The next cycle has wb_valid=1, wb_wen=in_wen, and wb_wdata = in_cp0_sel ? in_cp0_data : in_wdata.
  - Latency is 1 cycle. Back-to-back accepts are allowed, one per cycle.
- Load request:
  - Misaligned cases: LH/LHU with addr[0]=1; LW with addr[1:0]!=0. LB/LBU/LWL/LWR are never misaligned.
  - If misaligned, the next cycle has wb_valid=1, wb_wen=0 and misalign_err=1. State stays IDLE.
  - If aligned, go to WAIT and set counter=0.
- WAIT:
  - ram_rvalid=1: the next cycle has wb_valid=1, wb_wen=in_wen, formatted data, load_done=1. State returns to IDLE.
  - Otherwise the counter increments. When the counter reaches MAX_WAIT, the next cycle has wb_valid=1, wb_wen=0 and bus_err=1. State returns to IDLE.
- ram_rvalid is ignored in IDLE, so late responses after a timeout are dropped. ram_rvalid is not sampled in the accept cycle, so the RAM latency is at least 1.
- in_cp0_sel is ignored for load ops.
- wb_wen is forced to 0 whenever the captured waddr==0.
- wb_pc and wb_waddr are the captured values when wb_valid=1, and 0 otherwise.
- All outputs are registered. When wb_valid=0, wb_wen and wb_wdata are 0. Every pulse lasts exactly 1 cycle.
- Load formatting (o = addr[1:0], m = ram_rdata, r = in_rt_old):
  - LB/LBU: byte m[8o+7:8o], sign- or zero-extended.
  - LH/LHU: half m[16*o[1]+15:16*o[1]], sign- or zero-extended.
  - LW: m.
  - LWL by o:
    - o=0: {m[7:0], r[23:0]}
    - o=1: {m[15:0], r[15:0]}
    - o=2: {m[23:0], r[7:0]}
    - o=3: m
  - LWR by o:
    - o=0: m
    - o=1: {r[31:24], m[31:8]}
    - o=2: {r[31:16], m[31:16]}
    - o=3: {r[31:8], m[31:24]}
- The CP0 select is an explicit bit, so CP0 data of 0 is written correctly.

Test Plan:
- ALU op: wen=1, waddr=5, wdata=0x1234 → next cycle wb_valid=1, wen=1, waddr=5, wdata=0x1234; a second request the following cycle is also accepted.
- LB at addr 0x..03, ram_rdata=0x80FF_FF7F, rvalid 3 cycles later → busy and in_ready=0 for 3 cycles, then wdata=0xFFFFFF80 and load_done=1. The same case with LBU gives 0x00000080.
- LWL o=1, m=0xAABBCCDD, r=0x11223344 → wdata=0xCCDD3344. LWR o=2 → wdata=0x1122AABB.
- LW at addr 0x..02 → misalign_err=1, wb_wen=0, never busy. LH at addr 0x..02 with m=0x8001_0000 → 0xFFFF8001.
- MAX_WAIT=4 with no rvalid → bus_err pulse after 4 WAIT cycles, wb_wen=0; an rvalid one cycle later is ignored. MFC0 with cp0_data=0 and wdata=0x55 → wdata=0.
- rst=0 asserted during WAIT, then rvalid → outputs 0, state IDLE, no write. Load to waddr=0 → wb_valid=1, wb_wen=0.
